// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types and constants for the USB transmit sequencer
//
// Purpose: the sequencer state enum, the SYNC pattern, the CRC16 polynomial and
// seed, and a single-bit CRC16 step helper used by usb_crc16.
// The CRC state only exists when USB_TX_CRC16_EN is defined.
package usb_tx_pkg;

`ifdef USB_TX_CRC16_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        DATA   = 3'd2,
        CRC    = 3'd3,
        EOP    = 3'd4,
        IDLE_J = 3'd5
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        DATA   = 3'd2,
        EOP    = 3'd4,
        IDLE_J = 3'd5
    } tx_state_t;
`endif

    localparam logic [7:0]  SYNC_PATTERN = 8'h80;
    localparam logic [15:0] CRC16_POLY   = 16'h8005;
    localparam logic [15:0] CRC16_SEED   = 16'hFFFF;

    // One serial CRC16 step: feedback is the register MSB xor the incoming bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// rtl/usb_crc16.sv - serial CRC16 accumulator, one bit per enable
//
// Ports:
//   clk, n_rst : clock and asynchronous active-low reset (register forced to 0)
//   init       : load CRC16_SEED (start of packet); has priority over en
//   en         : fold din into the CRC this cycle
//   din        : payload bit
//   crc        : current CRC register
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        init,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc <= 16'h0000;
        end else if (init) begin
            crc <= CRC16_SEED;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end
    end

endmodule

// File: rtl/usb_tx_sequencer.sv
// rtl/usb_tx_sequencer.sv - USB packet transmit sequencer (SYNC, payload, optional CRC16, EOP, J)
//
// Optional feature: define USB_TX_CRC16_EN to append the inverted CRC16 of the
// payload (16 bits, LSB first) between the last data byte and EOP.
//
// Ports:
//   clk, n_rst     : system clock, asynchronous active-low reset
//   tx_start       : one-cycle packet request (ignored while busy)
//   tx_byte        : payload byte from upstream FIFO
//   tx_byte_valid  : tx_byte holds data
//   tx_last        : tx_byte is the final payload byte
//   tx_byte_ready  : byte accepted when valid and ready are both high
//   stuffing       : bit stuffer is inserting a bit this period (stall)
//   bit_strobe     : pulse on the last clock of every bit period
//   serial_out     : raw NRZ bit stream to the bit stuffer
//   eop            : SE0 request to the line driver
//   busy           : packet in progress
//   tx_done        : one-cycle completion pulse
//   tx_underrun    : sticky flag, packet aborted for lack of data
module usb_tx_sequencer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    input  logic       tx_byte_valid,
    input  logic       tx_last,
    output logic       tx_byte_ready,
    input  logic       stuffing,
    output logic       bit_strobe,
    output logic       serial_out,
    output logic       eop,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_underrun
);

    localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);

    tx_state_t   state;
    tx_state_t   state_d;
    logic [7:0]  cnt;
    logic [3:0]  bit_idx;
    logic [15:0] sh;
    logic        last_byte;

    logic        honour_stuff;
    logic        adv;
    logic        last_bit;
    logic        go_sync;
    logic        shift;
    logic        tick;
    logic        take;
    logic        to_eop;
    logic        underrun_set;
    logic        to_j;
    logic        finish;
    logic        to_crc;

    assign bit_strobe = busy && (cnt == CNT_MAX);

    // A stuffed period freezes the bit position; EOP and J are not subject to it.
`ifdef USB_TX_CRC16_EN
    assign honour_stuff = (state == SYNC) || (state == DATA) || (state == CRC);
`else
    assign honour_stuff = (state == SYNC) || (state == DATA);
`endif
    assign adv = bit_strobe && !(stuffing && honour_stuff);

    // A byte is requested after SYNC and after every byte except the last one.
    assign tx_byte_ready = adv && last_bit &&
                           ((state == SYNC) || ((state == DATA) && !last_byte));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        last_bit     = 1'b0;
        go_sync      = 1'b0;
        shift        = 1'b0;
        tick         = 1'b0;
        take         = 1'b0;
        to_eop       = 1'b0;
        underrun_set = 1'b0;
        to_j         = 1'b0;
        finish       = 1'b0;
        to_crc       = 1'b0;
        case (state)
            IDLE: begin
                if (tx_start) begin
                    state_d = SYNC;
                    go_sync = 1'b1;
                end
            end
            SYNC, DATA: begin
                last_bit = (bit_idx == 4'd7);
                if (adv) begin
                    if (!last_bit) begin
                        shift = 1'b1;
                        tick  = 1'b1;
                    end else if ((state == DATA) && last_byte) begin
`ifdef USB_TX_CRC16_EN
                        state_d = CRC;
                        to_crc  = 1'b1;
`else
                        state_d = EOP;
                        to_eop  = 1'b1;
`endif
                    end else if (tx_byte_valid) begin
                        state_d = DATA;
                        take    = 1'b1;
                    end else begin
                        state_d      = EOP;
                        to_eop       = 1'b1;
                        underrun_set = 1'b1;
                    end
                end
            end
`ifdef USB_TX_CRC16_EN
            CRC: begin
                last_bit = (bit_idx == 4'd15);
                if (adv) begin
                    if (!last_bit) begin
                        shift = 1'b1;
                        tick  = 1'b1;
                    end else begin
                        state_d = EOP;
                        to_eop  = 1'b1;
                    end
                end
            end
`endif
            EOP: begin
                last_bit = (bit_idx == 4'd1);
                if (adv) begin
                    if (!last_bit) begin
                        tick = 1'b1;
                    end else begin
                        state_d = IDLE_J;
                        to_j    = 1'b1;
                    end
                end
            end
            IDLE_J: begin
                last_bit = 1'b1;
                if (adv) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef USB_TX_CRC16_EN
    logic [15:0] crc;

    // Each payload bit is folded in when it is placed on serial_out, so the
    // register already covers the whole payload when CRC is entered.
    usb_crc16 u_crc16 (
        .clk   (clk),
        .n_rst (n_rst),
        .init  (go_sync),
        .en    (take || (shift && (state == DATA))),
        .din   (take ? tx_byte[0] : sh[1]),
        .crc   (crc)
    );
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt         <= 8'd0;
            bit_idx     <= 4'd0;
            sh          <= 16'h0000;
            last_byte   <= 1'b0;
            serial_out  <= 1'b1;
            eop         <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_done <= finish;

            if (!busy || (cnt == CNT_MAX)) begin
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end

            if (go_sync) begin
                busy        <= 1'b1;
                tx_underrun <= 1'b0;
                sh          <= {8'h00, SYNC_PATTERN};
                serial_out  <= SYNC_PATTERN[0];
                bit_idx     <= 4'd0;
                last_byte   <= 1'b0;
            end

            if (tick) begin
                bit_idx <= bit_idx + 4'd1;
            end

            if (shift) begin
                sh         <= sh >> 1;
                serial_out <= sh[1];
            end

            if (take) begin
                sh         <= {8'h00, tx_byte};
                serial_out <= tx_byte[0];
                bit_idx    <= 4'd0;
                last_byte  <= tx_last;
            end

`ifdef USB_TX_CRC16_EN
            if (to_crc) begin
                sh         <= ~crc;
                serial_out <= ~crc[0];
                bit_idx    <= 4'd0;
            end
`endif

            if (to_eop) begin
                serial_out <= 1'b0;
                eop        <= 1'b1;
                bit_idx    <= 4'd0;
                if (underrun_set) begin
                    tx_underrun <= 1'b1;
                end
            end

            if (to_j) begin
                serial_out <= 1'b1;
                eop        <= 1'b0;
            end

            if (finish) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// tb/tb_usb_tx_sequencer.sv - scoreboard bench for usb_tx_sequencer
module tb_usb_tx_sequencer;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_byte_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_byte_ready;
    logic       stuffing = 1'b0;
    logic       bit_strobe;
    logic       serial_out;
    logic       eop;
    logic       busy;
    logic       tx_done;
    logic       tx_underrun;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];
    logic [7:0] payload[$];
    int         pidx;

    usb_tx_sequencer #(.CLKS_PER_BIT(N)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .tx_start      (tx_start),
        .tx_byte       (tx_byte),
        .tx_byte_valid (tx_byte_valid),
        .tx_last       (tx_last),
        .tx_byte_ready (tx_byte_ready),
        .stuffing      (stuffing),
        .bit_strobe    (bit_strobe),
        .serial_out    (serial_out),
        .eop           (eop),
        .busy          (busy),
        .tx_done       (tx_done),
        .tx_underrun   (tx_underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_model();
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'hFFFF;
        foreach (payload[k]) begin
            b = payload[k];
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ b[i];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    // Expected {eop, serial_out} for every bit period of one packet.
    task automatic build_expected(input bit underrun);
        logic [7:0]  sp;
        logic [7:0]  b;
        logic [15:0] c;
        exp_q.delete();
        sp = 8'h80;
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, sp[i]});
        if (!underrun) begin
            foreach (payload[k]) begin
                b = payload[k];
                for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, b[i]});
            end
`ifdef USB_TX_CRC16_EN
            c = ~crc_model();
            for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, c[i]});
`else
            c = 16'h0000;
`endif
        end
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
    endtask

    task automatic drive_byte(input bit give_valid);
        if (pidx < payload.size()) begin
            tx_byte       = payload[pidx];
            tx_byte_valid = give_valid;
            tx_last       = (pidx == payload.size() - 1);
        end else begin
            tx_byte       = 8'h00;
            tx_byte_valid = 1'b0;
            tx_last       = 1'b0;
        end
    endtask

    task automatic run_packet(input string name, input bit give_valid, input int stuff_period,
                              input int restart_cycle, input int abort_cycle);
        int cyc;
        int period;
        int ready_cnt;
        int exp_done;
        int seen;
        bit accepted;
        bit done;
        cyc       = 0;
        period    = 0;
        ready_cnt = 0;
        accepted  = 1'b0;
        done      = 1'b0;
        exp_done  = 1 + exp_q.size() * N;
        pidx      = 0;
        drive_byte(give_valid);
        @(negedge clk);
        tx_start = 1'b1;
        while (!done && cyc < 60 * N) begin
            @(negedge clk);
            cyc++;
            tx_start = (cyc == restart_cycle);
            if (accepted) begin
                accepted = 1'b0;
                pidx++;
                drive_byte(give_valid);
            end
            if (cyc == abort_cycle) begin
                n_rst    = 1'b0;
                stuffing = 1'b0;
                #1;
                check({name, " rst serial_out"}, serial_out, 1);
                check({name, " rst eop"}, eop, 0);
                check({name, " rst busy"}, busy, 0);
                check({name, " rst bit_strobe"}, bit_strobe, 0);
                check({name, " rst ready"}, tx_byte_ready, 0);
                check({name, " rst tx_done"}, tx_done, 0);
                check({name, " rst underrun"}, tx_underrun, 0);
                exp_q.delete();
                repeat (2) @(negedge clk);
                n_rst = 1'b1;
                seen  = 0;
                repeat (30 * N) begin
                    @(negedge clk);
                    if (tx_done || eop || busy || !serial_out) seen++;
                end
                check({name, " quiet after reset"}, seen, 0);
                return;
            end
            stuffing = bit_strobe && (period == stuff_period);
            #1;
            if (tx_byte_ready) begin
                ready_cnt++;
                accepted = tx_byte_valid;
            end
            if (bit_strobe) begin
                if (exp_q.size() == 0) begin
                    check({name, " extra period"}, period, 32'hFFFF_FFFF);
                end else begin
                    check($sformatf("%s period %0d", name, period), {eop, serial_out}, exp_q.pop_front());
                end
                period++;
            end
            if (tx_done) begin
                done = 1'b1;
                check({name, " done cycle"}, cyc, exp_done);
                check({name, " busy at done"}, busy, 0);
            end
        end
        stuffing = 1'b0;
        tx_start = 1'b0;
        check({name, " done seen"}, done, 1);
        check({name, " periods left"}, exp_q.size(), 0);
        check({name, " ready pulses"}, ready_cnt, give_valid ? payload.size() : 1);
        check({name, " underrun"}, tx_underrun, !give_valid);
        @(negedge clk);
        check({name, " done one cycle"}, tx_done, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset serial_out", serial_out, 1);
        check("reset eop", eop, 0);
        check("reset busy", busy, 0);
        check("reset bit_strobe", bit_strobe, 0);
        check("reset ready", tx_byte_ready, 0);
        check("reset tx_done", tx_done, 0);
        check("reset underrun", tx_underrun, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        payload = '{8'hD5};
        build_expected(1'b0);
`ifndef USB_TX_CRC16_EN
        check("d5 period count", exp_q.size(), 19);
`endif
        run_packet("d5", 1'b1, -1, -1, -1);

        payload = '{8'hFE};
        build_expected(1'b0);
        exp_q.insert(13, exp_q[13]);
        run_packet("fe_stuff", 1'b1, 13, -1, -1);

        payload = '{8'h3C};
        build_expected(1'b0);
        exp_q.insert(7, exp_q[7]);
        run_packet("sync_stuff", 1'b1, 7, -1, -1);

        payload = '{8'hAA};
        build_expected(1'b1);
        run_packet("underrun", 1'b0, -1, -1, -1);

        payload = '{8'h00, 8'h01};
        build_expected(1'b0);
        run_packet("two_bytes", 1'b1, -1, -1, -1);

        payload = '{8'hD5};
        build_expected(1'b0);
        run_packet("start_busy", 1'b1, -1, 40, -1);

        payload = '{8'($urandom), 8'($urandom), 8'($urandom)};
        build_expected(1'b0);
        run_packet("random", 1'b1, -1, -1, -1);

        payload = '{8'h5A, 8'hC3};
        build_expected(1'b0);
        run_packet("abort", 1'b1, -1, -1, 8 * N + 20);

        payload = '{8'hD5};
        build_expected(1'b0);
        run_packet("after_abort", 1'b1, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
